sdf_stage_ctrl: RTL and testbench

Sequencer for one radix-2 single-delay-feedback (SDF) FFT stage. It drives the butterfly/feedback mux select and the twiddle ROM address for that stage. It also frames the stage output (valid, start-of-frame, end-of-frame) and flags malformed input framing. One instance sits beside each stage's delay line; the delay line shifts every clock, so all control is cycle-counted.

---
 rtl/sdf_stage_ctrl_if.sv | 24 ++
 rtl/sdf_stage_ctrl.sv | 111 +++++++++++
 tb/tb_sdf_stage_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sdf_stage_ctrl_if.sv
// Sample-framing and control bundle between an SDF FFT stage and its sequencer.
// master drives the input framing; slave (the sequencer) drives the stage controls.
interface sdf_stage_ctrl_if #(
    parameter int TW_AW = 5
);
    logic             in_valid;
    logic             in_sof;
    logic             bf_sel;
    logic [TW_AW-1:0] tw_addr;
    logic             out_valid;
    logic             out_sof;
    logic             out_eof;
    logic             err;

    modport master (
        output in_valid, in_sof,
        input  bf_sel, tw_addr, out_valid, out_sof, out_eof, err
    );

    modport slave (
        input  in_valid, in_sof,
        output bf_sel, tw_addr, out_valid, out_sof, out_eof, err
    );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: butterfly select, twiddle address, output framing.
// Define SDF_CTRL_ERR_EN to enable framing-error detection and recovery.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an accepted in_sof; previous flush may still run
//   FILL  | first DELAY samples of a block go into the delay line
//   BFLY  | second DELAY samples combine with the delay-line output
module sdf_stage_ctrl #(
    parameter int N     = 64,
    parameter int DELAY = 8,
    parameter int TW_AW = $clog2(N / 2)
) (
    input logic            clk,
    input logic            rst,
    sdf_stage_ctrl_if.slave bus
);
    localparam int STRIDE = N / (2 * DELAY);
    localparam int BLKS   = N / (2 * DELAY);
    localparam int CW     = $clog2(DELAY);
    localparam int BW     = (BLKS > 1) ? $clog2(BLKS) : 1;
    localparam int FW     = $clog2(DELAY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_BFLY = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] blk;
    logic [FW-1:0] flush_left;
    logic          last_blk_flush;

    wire cnt_last = (cnt == CW'(DELAY - 1));
    wire blk_last = (blk == BW'(BLKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            blk            <= '0;
            flush_left     <= '0;
            last_blk_flush <= 1'b0;
        end else begin
            // The delay line drains one sample per clock no matter what the input does.
            if (flush_left != '0)
                flush_left <= flush_left - 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_sof) begin
                        cnt   <= CW'(1);
                        blk   <= '0;
                        state <= S_FILL;
                    end
                end
                S_FILL, S_BFLY: begin
`ifdef SDF_CTRL_ERR_EN
                    if (!bus.in_valid) begin
                        state      <= S_IDLE;
                        cnt        <= '0;
                        blk        <= '0;
                        flush_left <= '0;
                    end else if (bus.in_sof) begin
                        state      <= S_FILL;
                        cnt        <= CW'(1);
                        blk        <= '0;
                        flush_left <= '0;
                    end else
`endif
                    begin
                        if (cnt_last) begin
                            cnt <= '0;
                            if (state == S_FILL) begin
                                state <= S_BFLY;
                            end else begin
                                flush_left     <= FW'(DELAY);
                                last_blk_flush <= blk_last;
                                if (blk_last) begin
                                    state <= S_IDLE;
                                end else begin
                                    blk   <= blk + 1'b1;
                                    state <= S_FILL;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // While flushing, the line output is sample (DELAY - flush_left) of the stored half-block.
    assign bus.bf_sel    = (state == S_BFLY);
    assign bus.out_valid = (state == S_BFLY) || (flush_left != '0);
    assign bus.tw_addr   = (flush_left != '0)
                         ? TW_AW'((DELAY - int'(flush_left)) * STRIDE)
                         : '0;
    assign bus.out_sof   = (state == S_BFLY) && (blk == '0) && (cnt == '0);
    assign bus.out_eof   = (flush_left == FW'(1)) && last_blk_flush;

`ifdef SDF_CTRL_ERR_EN
    // Flagged on the offending sample itself so the upstream source can tag it.
    assign bus.err = (state != S_IDLE) && (!bus.in_valid || bus.in_sof);
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Scoreboard bench for sdf_stage_ctrl: closed-form per-cycle expectations per frame,
// queued at drive time and compared when outputs are sampled on the falling edge.
module tb_sdf_stage_ctrl;
    localparam int NN  = 64;
    localparam int DD  = 8;
    localparam int AW  = $clog2(NN / 2);
    localparam int STR = NN / (2 * DD);
    localparam int NEVER = 100000;

    typedef logic [AW+4:0] ovec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdf_stage_ctrl_if #(.TW_AW(AW)) bus ();

    sdf_stage_ctrl #(.N(NN), .DELAY(DD), .TW_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    v_stim[256];
    bit    s_stim[256];
    int    fr_s[$];
    int    fr_e[$];
    int    err_c[$];
    int    rst_c;
    ovec_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ovec_t observed();
        return {bus.bf_sel, bus.tw_addr, bus.out_valid, bus.out_sof, bus.out_eof, bus.err};
    endfunction

    // Each frame started at fr_s contributes until its cut-off cycle fr_e (inclusive).
    function automatic ovec_t model(input int t);
        logic          bf = 1'b0;
        logic          ov = 1'b0;
        logic          so = 1'b0;
        logic          eo = 1'b0;
        logic          er = 1'b0;
        logic [AW-1:0] tw = '0;
        foreach (fr_s[i]) begin
            int d;
            d = t - fr_s[i];
            if (t > fr_e[i] || d < 0 || d >= NN + DD) continue;
            if (d < NN && (d % (2 * DD)) >= DD) begin
                bf = 1'b1;
                ov = 1'b1;
            end
            if (d >= 2 * DD && ((d - 2 * DD) % (2 * DD)) < DD) begin
                ov = 1'b1;
                tw = AW'(((d - 2 * DD) % (2 * DD)) * STR);
            end
            if (d == DD) so = 1'b1;
            if (d == NN + DD - 1) eo = 1'b1;
        end
        foreach (err_c[i]) if (err_c[i] == t) er = 1'b1;
        return {bf, tw, ov, so, eo, er};
    endfunction

    task automatic new_case();
        foreach (v_stim[i]) begin
            v_stim[i] = 1'b0;
            s_stim[i] = 1'b0;
        end
        fr_s.delete();
        fr_e.delete();
        err_c.delete();
        exp_q.delete();
        rst_c = -10;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input int a, input int b);
        for (int i = a; i <= b; i++) v_stim[i] = 1'b1;
    endtask

    task automatic add_frame(input int s, input int e);
        fr_s.push_back(s);
        fr_e.push_back(e);
    endtask

    task automatic run_case(input string name, input int len);
        for (int c = 0; c < len; c++) begin
            ovec_t e;
            bus.in_valid = v_stim[c];
            bus.in_sof   = s_stim[c];
            exp_q.push_back(model(c));
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("%s c%0d", name, c), observed(), e);
            if (c == rst_c) begin
                #1 rst = 1'b1;
                #1 chk($sformatf("%s async_rst c%0d", name, c), observed(), '0);
            end
            if (c == rst_c + 1) rst = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        #1 chk("reset_state", observed(), '0);

        new_case();
        s_stim[0] = 1'b1;
        set_valid(0, 63);
        add_frame(0, NEVER);
        run_case("single", 80);

        new_case();
        s_stim[0]  = 1'b1;
        s_stim[64] = 1'b1;
        set_valid(0, 127);
        add_frame(0, NEVER);
        add_frame(64, NEVER);
        run_case("b2b", 145);

        new_case();
        s_stim[0] = 1'b1;
        set_valid(0, 19);
`ifdef SDF_CTRL_ERR_EN
        add_frame(0, 20);
        err_c.push_back(20);
`else
        add_frame(0, NEVER);
`endif
        run_case("drop", 80);

        new_case();
        s_stim[0]  = 1'b1;
        s_stim[30] = 1'b1;
        set_valid(0, 93);
`ifdef SDF_CTRL_ERR_EN
        add_frame(0, 30);
        add_frame(30, NEVER);
        err_c.push_back(30);
`else
        add_frame(0, NEVER);
`endif
        run_case("resof", 110);

        new_case();
        s_stim[0]  = 1'b1;
        s_stim[50] = 1'b1;
        set_valid(0, 113);
        add_frame(0, 40);
        add_frame(50, NEVER);
        rst_c = 40;
        run_case("midrst", 130);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
